// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with load extraction, misalignment detection and writeback select
//   Inputs : CLK, RST_N (async, active low), StallW, FlushW, M-stage control/data
//            (RegWriteM, MemtoRegM, LoadTypeM, ALUOutM, WriteRegM) and memory read data RD.
//   Outputs: register-file write port (RegWriteW, WriteRegW, ResultW), AlignErrW, LoadCntW.
module mem_wb_stage #(
   parameter int          CNT_W     = 16,
   parameter logic [31:0] UNDEF_VAL = 32'hxxxxxxxx
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             StallW,
   input  logic             FlushW,
   input  logic             RegWriteM,
   input  logic             MemtoRegM,
   input  logic [2:0]       LoadTypeM,
   input  logic [31:0]      ALUOutM,
   input  logic [4:0]       WriteRegM,
   input  logic [31:0]      RD,
   output logic             RegWriteW,
   output logic [4:0]       WriteRegW,
   output logic [31:0]      ResultW,
   output logic             AlignErrW,
   output logic [CNT_W-1:0] LoadCntW
);
   logic             reg_write_q, reg_write_d;
   logic             mem_to_reg_q, mem_to_reg_d;
   logic [2:0]       load_type_q, load_type_d;
   logic [31:0]      alu_out_q, alu_out_d;
   logic [4:0]       write_reg_q, write_reg_d;
   logic             stall_q, stall_d;
   logic [31:0]      rd_hold_q, rd_hold_d;
   logic [CNT_W-1:0] load_cnt_q, load_cnt_d;
   logic [31:0]      word, load_v;
   logic [1:0]       off;
   logic [7:0]       lane_b;
   logic [15:0]      lane_h;
   logic             is_lw, is_h;

   // RD is only captured on the first stall edge, so a long stall keeps the
   // data that belonged to the load even if memory changes underneath it.
   always_comb begin
      reg_write_d  = reg_write_q;
      mem_to_reg_d = mem_to_reg_q;
      load_type_d  = load_type_q;
      alu_out_d    = alu_out_q;
      write_reg_d  = write_reg_q;
      stall_d      = stall_q;
      rd_hold_d    = rd_hold_q;
      if (FlushW) begin
         reg_write_d  = 1'b0;
         mem_to_reg_d = 1'b0;
         load_type_d  = 3'd0;
         alu_out_d    = 32'd0;
         write_reg_d  = 5'd0;
         stall_d      = 1'b0;
      end else if (StallW) begin
         stall_d   = 1'b1;
         rd_hold_d = stall_q ? rd_hold_q : RD;
      end else begin
         reg_write_d  = RegWriteM;
         mem_to_reg_d = MemtoRegM;
         load_type_d  = LoadTypeM;
         alu_out_d    = ALUOutM;
         write_reg_d  = WriteRegM;
         stall_d      = 1'b0;
      end
   end

   // Big-endian lanes: offset 0 selects the most significant byte/half.
   always_comb begin
      word   = stall_q ? rd_hold_q : RD;
      off    = alu_out_q[1:0];
      lane_b = off == 2'd0 ? word[31:24] : off == 2'd1 ? word[23:16] :
               off == 2'd2 ? word[15:8]  : word[7:0];
      lane_h = off[1] ? word[15:0] : word[31:16];
      is_h   = load_type_q == 3'd1 || load_type_q == 3'd2;
      is_lw  = !is_h && load_type_q != 3'd3 && load_type_q != 3'd4;
      load_v = load_type_q == 3'd1 ? {{16{lane_h[15]}}, lane_h} :
               load_type_q == 3'd2 ? {16'd0, lane_h} :
               load_type_q == 3'd3 ? {{24{lane_b[7]}}, lane_b} :
               load_type_q == 3'd4 ? {24'd0, lane_b} : word;
      AlignErrW  = mem_to_reg_q && ((is_lw && off != 2'd0) || (is_h && off[0]));
      ResultW    = AlignErrW ? UNDEF_VAL : mem_to_reg_q ? load_v : alu_out_q;
      RegWriteW  = reg_write_q && !AlignErrW && write_reg_q != 5'd0;
      WriteRegW  = write_reg_q;
      // A stalled load is counted only on the edge where it actually leaves W.
      load_cnt_d = load_cnt_q + CNT_W'(RegWriteW && mem_to_reg_q && !StallW && !FlushW);
      LoadCntW   = load_cnt_q;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         reg_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         load_type_q  <= 3'd0;
         alu_out_q    <= 32'd0;
         write_reg_q  <= 5'd0;
         stall_q      <= 1'b0;
         rd_hold_q    <= 32'd0;
         load_cnt_q   <= '0;
      end else begin
         reg_write_q  <= reg_write_d;
         mem_to_reg_q <= mem_to_reg_d;
         load_type_q  <= load_type_d;
         alu_out_q    <= alu_out_d;
         write_reg_q  <= write_reg_d;
         stall_q      <= stall_d;
         rd_hold_q    <= rd_hold_d;
         load_cnt_q   <= load_cnt_d;
      end
   end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: self-checking bench for mem_wb_stage (vector table + scoreboard + corner sequences)
module tb_mem_wb_stage;
   logic        CLK = 1'b0, RST_N = 1'b0, StallW = 1'b0, FlushW = 1'b0;
   logic        RegWriteM = 1'b0, MemtoRegM = 1'b0;
   logic [2:0]  LoadTypeM = 3'd0;
   logic [31:0] ALUOutM = 32'd0, RD = 32'd0;
   logic [4:0]  WriteRegM = 5'd0;
   logic        RegWriteW, AlignErrW;
   logic [4:0]  WriteRegW;
   logic [31:0] ResultW;
   logic [15:0] LoadCntW;
   int tests = 0, fails = 0;
   int exp_cnt = 0;

   typedef struct {
      logic        we_m;
      logic        mtr;
      logic [2:0]  lt;
      logic [31:0] alu;
      logic [4:0]  wr;
      logic [31:0] rd;
      logic        exp_we;
      logic [31:0] exp_res;
      logic        exp_err;
   } vec_t;

   localparam int NV = 15;
   vec_t vecs[NV];
   vec_t exp_q[$];
   vec_t cur;

   mem_wb_stage dut (
      .CLK(CLK), .RST_N(RST_N), .StallW(StallW), .FlushW(FlushW),
      .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .LoadTypeM(LoadTypeM),
      .ALUOutM(ALUOutM), .WriteRegM(WriteRegM), .RD(RD),
      .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
      .AlignErrW(AlignErrW), .LoadCntW(LoadCntW)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_m(input logic we, input logic mtr, input logic [2:0] lt,
                          input logic [31:0] alu, input logic [4:0] wr);
      RegWriteM = we;
      MemtoRegM = mtr;
      LoadTypeM = lt;
      ALUOutM   = alu;
      WriteRegM = wr;
   endtask

   initial begin
      //          we mtr lt    alu          wr     rd             exp_we exp_res        err
      vecs[0]  = '{1'b1, 1'b0, 3'd0, 32'h1234,  5'd5,  32'h0,         1'b1, 32'h00001234, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, 3'd3, 32'h102,   5'd7,  32'h1122F344,  1'b1, 32'hFFFFFFF3, 1'b0};
      vecs[2]  = '{1'b1, 1'b1, 3'd4, 32'h102,   5'd8,  32'h1122F344,  1'b1, 32'h000000F3, 1'b0};
      vecs[3]  = '{1'b1, 1'b1, 3'd2, 32'h102,   5'd9,  32'h1122F344,  1'b1, 32'h0000F344, 1'b0};
      vecs[4]  = '{1'b1, 1'b1, 3'd1, 32'h200,   5'd10, 32'h80010000,  1'b1, 32'hFFFF8001, 1'b0};
      vecs[5]  = '{1'b1, 1'b1, 3'd3, 32'h300,   5'd11, 32'h7F000000,  1'b1, 32'h0000007F, 1'b0};
      vecs[6]  = '{1'b1, 1'b1, 3'd4, 32'h303,   5'd12, 32'h000000AB,  1'b1, 32'h000000AB, 1'b0};
      vecs[7]  = '{1'b1, 1'b1, 3'd0, 32'h400,   5'd13, 32'hCAFEBABE,  1'b1, 32'hCAFEBABE, 1'b0};
      vecs[8]  = '{1'b1, 1'b1, 3'd0, 32'h406,   5'd14, 32'h11111111,  1'b0, 32'h0,        1'b1};
      vecs[9]  = '{1'b1, 1'b1, 3'd1, 32'h101,   5'd15, 32'h22222222,  1'b0, 32'h0,        1'b1};
      vecs[10] = '{1'b1, 1'b0, 3'd0, 32'hABCD,  5'd0,  32'h0,         1'b0, 32'h0000ABCD, 1'b0};
      vecs[11] = '{1'b1, 1'b1, 3'd6, 32'h200,   5'd16, 32'h01020304,  1'b1, 32'h01020304, 1'b0};
      vecs[12] = '{1'b1, 1'b1, 3'd2, 32'h201,   5'd17, 32'h33333333,  1'b0, 32'h0,        1'b1};
      vecs[13] = '{1'b0, 1'b1, 3'd3, 32'h501,   5'd18, 32'h00FE0000,  1'b0, 32'hFFFFFFFE, 1'b0};
      vecs[14] = '{1'b1, 1'b1, 3'd4, 32'h601,   5'd19, 32'h12345678,  1'b1, 32'h00000034, 1'b0};

      // Reset held with random inputs: outputs must stay zero.
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         drive_m(1'($urandom), 1'($urandom), 3'($urandom), $urandom, 5'($urandom));
         RD = $urandom;
         StallW = 1'($urandom);
         #1;
         check("rst_we", {31'd0, RegWriteW}, 32'd0);
         check("rst_wreg", {27'd0, WriteRegW}, 32'd0);
         check("rst_res", ResultW, 32'd0);
         check("rst_err", {31'd0, AlignErrW}, 32'd0);
         check("rst_cnt", {16'd0, LoadCntW}, 32'd0);
      end
      @(negedge CLK);
      drive_m(1'b0, 1'b0, 3'd0, 32'd0, 5'd0);
      StallW = 1'b0;
      RD = 32'd0;
      RST_N = 1'b1;

      // Back-to-back table: vector i enters M while vector i-1 sits in W with its RD.
      for (int i = 0; i <= NV; i++) begin
         @(negedge CLK);
         if (i < NV) begin
            drive_m(vecs[i].we_m, vecs[i].mtr, vecs[i].lt, vecs[i].alu, vecs[i].wr);
            exp_q.push_back(vecs[i]);
         end else
            drive_m(1'b0, 1'b0, 3'd0, 32'd0, 5'd0);
         if (i > 0) begin
            cur = exp_q.pop_front();
            RD = cur.rd;
            #1;
            check($sformatf("v%0d_we", i - 1), {31'd0, RegWriteW}, {31'd0, cur.exp_we});
            check($sformatf("v%0d_wreg", i - 1), {27'd0, WriteRegW}, {27'd0, cur.wr});
            check($sformatf("v%0d_err", i - 1), {31'd0, AlignErrW}, {31'd0, cur.exp_err});
            if (!cur.exp_err)
               check($sformatf("v%0d_res", i - 1), ResultW, cur.exp_res);
            if (cur.exp_we && cur.mtr) exp_cnt++;
         end
      end
      @(posedge CLK);
      #1 check("tbl_cnt", {16'd0, LoadCntW}, exp_cnt);

      // Stall for three edges with RD changing underneath the held load.
      @(negedge CLK);
      drive_m(1'b1, 1'b1, 3'd0, 32'h40, 5'd3);
      @(negedge CLK);
      drive_m(1'b0, 1'b0, 3'd0, 32'd0, 5'd0);
      RD = 32'h55AA1234;
      StallW = 1'b1;
      #1 check("stall_pre_res", ResultW, 32'h55AA1234);
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         RD = 32'hDEADBEEF;
         if (k == 2) StallW = 1'b0;
         #1;
         check($sformatf("stall%0d_res", k), ResultW, 32'h55AA1234);
         check($sformatf("stall%0d_we", k), {31'd0, RegWriteW}, 32'd1);
         check($sformatf("stall%0d_cnt", k), {16'd0, LoadCntW}, exp_cnt);
      end
      @(posedge CLK);
      exp_cnt++;
      #1 check("stall_rel_cnt", {16'd0, LoadCntW}, exp_cnt);

      // Stall and flush on the same edge: flush wins.
      @(negedge CLK);
      drive_m(1'b1, 1'b1, 3'd0, 32'h80, 5'd4);
      RD = 32'h77777777;
      StallW = 1'b1;
      FlushW = 1'b1;
      @(negedge CLK);
      StallW = 1'b0;
      FlushW = 1'b0;
      drive_m(1'b0, 1'b0, 3'd0, 32'd0, 5'd0);
      #1;
      check("sf_we", {31'd0, RegWriteW}, 32'd0);
      check("sf_res", ResultW, 32'd0);
      check("sf_wreg", {27'd0, WriteRegW}, 32'd0);
      check("sf_cnt", {16'd0, LoadCntW}, exp_cnt);
      // stall_q must be clear: the next load uses live RD, not the stale hold.
      @(negedge CLK);
      drive_m(1'b1, 1'b1, 3'd0, 32'h84, 5'd6);
      @(negedge CLK);
      drive_m(1'b0, 1'b0, 3'd0, 32'd0, 5'd0);
      RD = 32'h0BADF00D;
      #1 check("sf_live_rd", ResultW, 32'h0BADF00D);
      @(posedge CLK);
      exp_cnt++;

      // Asynchronous reset in the middle of a stall discards the held data.
      @(negedge CLK);
      drive_m(1'b1, 1'b1, 3'd0, 32'h10, 5'd2);
      @(negedge CLK);
      drive_m(1'b0, 1'b0, 3'd0, 32'd0, 5'd0);
      RD = 32'h13572468;
      StallW = 1'b1;
      @(posedge CLK);
      #2 RD = 32'hDEADBEEF;
      #1;
      check("rs_hold_res", ResultW, 32'h13572468);
      check("rs_pre_cnt", {16'd0, LoadCntW}, exp_cnt);
      RST_N = 1'b0;
      #1;
      check("rs_we", {31'd0, RegWriteW}, 32'd0);
      check("rs_res", ResultW, 32'd0);
      check("rs_cnt", {16'd0, LoadCntW}, 32'd0);
      @(negedge CLK);
      StallW = 1'b0;
      RST_N = 1'b1;

      // Counter wrap: 65539 loads retire back to back.
      @(negedge CLK);
      drive_m(1'b1, 1'b1, 3'd0, 32'd0, 5'd1);
      @(negedge CLK);
      RD = 32'h2468ACE0;
      #1 check("wrap_first_res", ResultW, 32'h2468ACE0);
      repeat (65538) @(negedge CLK);
      drive_m(1'b0, 1'b0, 3'd0, 32'd0, 5'd0);
      @(posedge CLK);
      #1 check("wrap_cnt", {16'd0, LoadCntW}, (65539 % 65536));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
